// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester round-robin arbiter for the shared main memory
//
// Purpose: serialises I-cache reads and D-cache reads/writes onto one
// single-ported memory. One request is accepted at a time. The arbiter issues
// one command, waits for the memory ack or for a timeout, then returns the
// result with a one-cycle done pulse. It also keeps saturating grant counters.
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   ic_req, ic_addr               I-cache read request (held until ic_done)
//   ic_done, ic_rdata             I-cache completion pulse and read data
//   dc_req, dc_wr, dc_addr,
//   dc_wdata                      D-cache request (held until dc_done)
//   dc_done, dc_rdata             D-cache completion pulse and read data
//   err                           high with the done pulse on a timed-out access
//   mem_rd, mem_wr                one-cycle memory command pulses
//   mem_addr, mem_wdata           command address/data, held ISSUE..WAIT
//   mem_busy                      memory cannot take a command this cycle
//   mem_ack, mem_rdata            one-cycle completion and read data
//   ic_gnt_cnt, dc_gnt_cnt        saturating grant counters
`timescale 1ns/1ps

module mem_arbiter #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ic_req,
   input  logic [15:0] ic_addr,
   output logic        ic_done,
   output logic [15:0] ic_rdata,
   input  logic        dc_req,
   input  logic        dc_wr,
   input  logic [15:0] dc_addr,
   input  logic [15:0] dc_wdata,
   output logic        dc_done,
   output logic [15:0] dc_rdata,
   output logic        err,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic        mem_busy,
   input  logic        mem_ack,
   input  logic [15:0] mem_rdata,
   output logic [15:0] ic_gnt_cnt,
   output logic [15:0] dc_gnt_cnt
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t      state;
   state_t      state_nx;

   // owner/last: 0 = I-cache, 1 = D-cache
   logic        owner;
   logic        last;
   logic [7:0]  wait_cnt;
   logic [15:0] resp;
   logic        err_flag;
   logic [15:0] addr_q;
   logic [15:0] wdata_q;
   logic        wr_q;
   logic [15:0] ic_cnt;
   logic [15:0] dc_cnt;

   logic        grant;
   logic        grant_d;
   logic        cmd_fire;
   logic        timeout_hit;
   logic        in_done;

   // On a tie the requester that was not served last wins.
   assign grant       = (state == IDLE) && (ic_req || dc_req);
   assign grant_d     = dc_req && (!ic_req || !last);
   assign cmd_fire    = (state == ISSUE) && !mem_busy;
   // The counter holds the number of WAIT cycles already spent, so this cycle
   // is the TIMEOUT-th one when count+1 equals TIMEOUT.
   assign timeout_hit = (({1'b0, wait_cnt} + 9'd1) == 9'(TIMEOUT));

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (grant) state_nx = ISSUE;
         ISSUE:   if (!mem_busy) state_nx = WAIT;
         WAIT:    if (mem_ack || timeout_hit) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         owner    <= 1'b0;
         last     <= 1'b0;
         wait_cnt <= 8'd0;
         resp     <= 16'h0000;
         err_flag <= 1'b0;
         addr_q   <= 16'h0000;
         wdata_q  <= 16'h0000;
         wr_q     <= 1'b0;
         ic_cnt   <= 16'h0000;
         dc_cnt   <= 16'h0000;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: begin
               if (grant) begin
                  owner   <= grant_d;
                  last    <= grant_d;
                  addr_q  <= grant_d ? dc_addr : ic_addr;
                  wdata_q <= grant_d ? dc_wdata : 16'h0000;
                  wr_q    <= grant_d && dc_wr;
                  if (grant_d) begin
                     if (dc_cnt != 16'hFFFF) dc_cnt <= dc_cnt + 16'd1;
                  end else begin
                     if (ic_cnt != 16'hFFFF) ic_cnt <= ic_cnt + 16'd1;
                  end
               end
            end
            ISSUE: begin
               if (!mem_busy) wait_cnt <= 8'd0;
            end
            WAIT: begin
               if (mem_ack) begin
                  resp     <= wr_q ? 16'h0000 : mem_rdata;
                  err_flag <= 1'b0;
               end else if (timeout_hit) begin
                  resp     <= 16'h0000;
                  err_flag <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // Command pulses decode the registered state, gated by busy so a stalled
   // ISSUE emits nothing.
   assign mem_rd     = cmd_fire && !wr_q;
   assign mem_wr     = cmd_fire && wr_q;
   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;

   assign in_done    = (state == DONE);
   assign ic_done    = in_done && !owner;
   assign dc_done    = in_done && owner;
   assign ic_rdata   = ic_done ? resp : 16'h0000;
   assign dc_rdata   = dc_done ? resp : 16'h0000;
   assign err        = in_done && err_flag;

   assign ic_gnt_cnt = ic_cnt;
   assign dc_gnt_cnt = dc_cnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a behavioural memory
`timescale 1ns/1ps

module tb_mem_arbiter;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        ic_req, dc_req, dc_wr;
   logic [15:0] ic_addr, dc_addr, dc_wdata;
   logic        ic_done, dc_done, err, mem_rd, mem_wr;
   logic [15:0] ic_rdata, dc_rdata, mem_addr, mem_wdata;
   logic [15:0] ic_gnt_cnt, dc_gnt_cnt;
   logic        mem_busy, mem_ack;
   logic [15:0] mem_rdata;

   logic        mem_ack_model, ack_man, busy_rand, busy_man;
   logic        mem_en, rand_busy_en;
   int          lat_fixed;

   assign mem_ack  = mem_ack_model | ack_man;
   assign mem_busy = busy_rand | busy_man;

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;

   typedef struct {
      int          cyc;
      logic        wr;
      logic [15:0] addr;
      logic [15:0] wdata;
   } cmd_t;

   cmd_t        cmd_log[$];
   logic [16:0] ic_q[$];
   logic [16:0] dc_q[$];
   logic [15:0] ic_m, dc_m;
   logic [15:0] mem_arr [0:65535];
   logic [15:0] ref_mem [0:15];

   mem_arbiter #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .ic_req(ic_req), .ic_addr(ic_addr), .ic_done(ic_done), .ic_rdata(ic_rdata),
      .dc_req(dc_req), .dc_wr(dc_wr), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
      .dc_done(dc_done), .dc_rdata(dc_rdata), .err(err),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_busy(mem_busy), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .ic_gnt_cnt(ic_gnt_cnt), .dc_gnt_cnt(dc_gnt_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] ifunc(input logic [15:0] a);
      return 16'hBEEF ^ ((a - 16'h0040) * 16'h0101);
   endfunction

   function automatic logic [15:0] sat(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   // Behavioural memory: records every command, stores writes, acks after a latency.
   initial begin
      int          lat;
      logic        c_wr;
      logic [15:0] c_addr;
      cmd_t        c;
      mem_ack_model = 1'b0;
      mem_rdata     = 16'h0000;
      forever begin
         @(negedge clk); #1;
         if (mem_rd || mem_wr) chk("cmd_exclusive", {31'b0, mem_rd & mem_wr}, 32'd0);
         if (rst && (mem_rd || mem_wr)) begin
            c.cyc = cyc; c.wr = mem_wr; c.addr = mem_addr; c.wdata = mem_wdata;
            cmd_log.push_back(c);
            c_wr   = mem_wr;
            c_addr = mem_addr;
            if (c_wr) mem_arr[c_addr] = mem_wdata;
            if (mem_en) begin
               lat = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 3));
               repeat (lat) @(negedge clk);
               mem_ack_model = 1'b1;
               mem_rdata     = c_wr ? 16'($urandom) : mem_arr[c_addr];
               @(negedge clk);
               mem_ack_model = 1'b0;
               mem_rdata     = 16'($urandom);
            end
         end
      end
   end

   initial begin
      busy_rand = 1'b0;
      forever begin
         @(negedge clk);
         busy_rand = rand_busy_en && ($urandom_range(0, 3) == 0);
      end
   end

   // Scoreboard monitor: every done pulse pops one expected {err, rdata}.
   initial begin
      logic [16:0] e;
      forever begin
         @(negedge clk); #1;
         if (ic_done && dc_done) chk("done_exclusive", 32'd1, 32'd0);
         if (ic_done) begin
            if (ic_q.size() == 0) chk("ic_unexpected_done", 32'd1, 32'd0);
            else begin
               e = ic_q.pop_front();
               chk("ic_resp", {15'b0, err, ic_rdata}, {15'b0, e});
            end
         end
         if (dc_done) begin
            if (dc_q.size() == 0) chk("dc_unexpected_done", 32'd1, 32'd0);
            else begin
               e = dc_q.pop_front();
               chk("dc_resp", {15'b0, err, dc_rdata}, {15'b0, e});
            end
         end
      end
   end

   initial begin
      #500000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   task automatic ic_txn(input logic [15:0] a, output int dcyc);
      ic_addr = a;
      ic_req  = 1'b1;
      ic_q.push_back({1'b0, ifunc(a)});
      ic_m = sat(ic_m);
      dcyc = -1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk); #1;
         if (ic_done) begin dcyc = cyc; break; end
      end
      if (dcyc < 0) chk("ic_done_wait", 32'd0, 32'd1);
      ic_req = 1'b0;
   endtask

   task automatic dc_txn(input logic wr, input logic [15:0] a, input logic [15:0] d,
                         input logic to, output int dcyc);
      dc_wr    = wr;
      dc_addr  = a;
      dc_wdata = d;
      dc_req   = 1'b1;
      if (to) dc_q.push_back(17'h10000);
      else if (wr) begin
         dc_q.push_back(17'h00000);
         ref_mem[a[3:0]] = d;
      end else dc_q.push_back({1'b0, ref_mem[a[3:0]]});
      dc_m = sat(dc_m);
      dcyc = -1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk); #1;
         if (dc_done) begin dcyc = cyc; break; end
      end
      if (dcyc < 0) chk("dc_done_wait", 32'd0, 32'd1);
      dc_req = 1'b0;
   endtask

   task automatic idle_gap();
      @(negedge clk); #1;
   endtask

   task automatic late_ack_check(input string name);
      int n = 0;
      @(negedge clk); ack_man = 1'b1;
      @(negedge clk); ack_man = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1;
         if (ic_done || dc_done) n++;
      end
      chk(name, n, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0; ic_req = 1'b0; dc_req = 1'b0;
      ic_q.delete(); dc_q.delete();
      ic_m = 16'h0; dc_m = 16'h0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk); #1;
   endtask

   task automatic chk_zero_outputs(input string name);
      chk({name, "_ctl"}, {27'b0, ic_done, dc_done, err, mem_rd, mem_wr}, 32'd0);
      chk({name, "_bus"}, {mem_addr, mem_wdata}, 32'd0);
      chk({name, "_rdata"}, {ic_rdata, dc_rdata}, 32'd0);
      chk({name, "_cnts"}, {ic_gnt_cnt, dc_gnt_cnt}, 32'd0);
   endtask

   initial begin
      int k, dcyc, n;
      logic found;
      rst = 1'b0; ic_req = 1'b0; dc_req = 1'b0; dc_wr = 1'b0;
      ic_addr = 16'h0; dc_addr = 16'h0; dc_wdata = 16'h0;
      ack_man = 1'b0; busy_man = 1'b0; mem_en = 1'b1; rand_busy_en = 1'b0; lat_fixed = 0;
      ic_m = 16'h0; dc_m = 16'h0;
      for (int i = 0; i < 16; i++) begin
         mem_arr[16'h0040 + 16'(i)] = ifunc(16'h0040 + 16'(i));
         mem_arr[16'h1000 + 16'(i)] = 16'h0000;
         ref_mem[i] = 16'h0000;
      end

      repeat (2) @(negedge clk); #1;
      chk_zero_outputs("reset_state");
      @(negedge clk); rst = 1'b1;
      @(negedge clk); #1;

      // Single I-cache read, memory latency 2.
      lat_fixed = 2; cmd_log.delete(); k = cyc;
      ic_txn(16'h0040, dcyc);
      chk("t1_cmd_count", cmd_log.size(), 1);
      if (cmd_log.size() >= 1) begin
         chk("t1_cmd_cycle", cmd_log[0].cyc, k + 1);
         chk("t1_cmd_rd_addr", {15'b0, cmd_log[0].wr, cmd_log[0].addr}, 32'h0000_0040);
      end
      chk("t1_done_cycle", dcyc, k + 4);
      chk("t1_ic_gnt_cnt", ic_gnt_cnt, ic_m);

      // Simultaneous requests after reset: D first, then alternation.
      do_reset();
      lat_fixed = 1; cmd_log.delete();
      dc_wr = 1'b1; dc_addr = 16'h1000; dc_wdata = 16'h1234; ic_addr = 16'h0042;
      ref_mem[0] = 16'h1234;
      repeat (2) begin
         dc_q.push_back(17'h00000);
         ic_q.push_back({1'b0, ifunc(16'h0042)});
         ic_m = sat(ic_m); dc_m = sat(dc_m);
      end
      ic_req = 1'b1; dc_req = 1'b1;
      n = 0;
      for (int i = 0; i < 100 && n < 4; i++) begin
         @(negedge clk); #1;
         if (ic_done || dc_done) begin
            n++;
            if (n == 4) begin ic_req = 1'b0; dc_req = 1'b0; end
         end
      end
      ic_req = 1'b0; dc_req = 1'b0;
      repeat (3) @(negedge clk); #1;
      chk("t2_done_count", n, 4);
      chk("t2_cmd_count", cmd_log.size(), 4);
      if (cmd_log.size() == 4) begin
         chk("t2_first_d_write", {cmd_log[0].wr, 15'b0, cmd_log[0].addr},
             {1'b1, 15'b0, 16'h1000});
         chk("t2_first_d_wdata", cmd_log[0].wdata, 16'h1234);
         chk("t2_order", {28'b0, cmd_log[0].wr, cmd_log[1].wr, cmd_log[2].wr, cmd_log[3].wr},
             32'b1010);
         chk("t2_i_addr", cmd_log[1].addr, 16'h0042);
         chk("t2_bubble", cmd_log[1].cyc - cmd_log[0].cyc, 4);
      end
      chk("t2_cnts", {ic_gnt_cnt, dc_gnt_cnt}, {ic_m, dc_m});

      // Busy for three ISSUE cycles stretches the command by three.
      idle_gap();
      lat_fixed = 1; cmd_log.delete(); k = cyc;
      busy_man = 1'b1;
      fork
         ic_txn(16'h0045, dcyc);
         begin repeat (4) @(negedge clk); busy_man = 1'b0; end
      join
      chk("t3_cmd_count", cmd_log.size(), 1);
      if (cmd_log.size() >= 1) chk("t3_cmd_cycle", cmd_log[0].cyc, k + 4);
      chk("t3_done_cycle", dcyc, k + 6);

      // Timeout with no ack, then a late ack that must be ignored.
      idle_gap();
      mem_en = 1'b0; cmd_log.delete(); k = cyc;
      dc_txn(1'b0, 16'h1004, 16'h0, 1'b1, dcyc);
      if (cmd_log.size() >= 1) chk("t4_cmd_cycle", cmd_log[0].cyc, k + 1);
      else chk("t4_cmd_count", cmd_log.size(), 1);
      chk("t4_done_cycle", dcyc, k + 1 + TO + 1);
      late_ack_check("t4_late_ack_nodone");

      // Reset asserted during WAIT.
      idle_gap();
      ic_addr = 16'h0044; ic_req = 1'b1; found = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); #1;
         if (mem_rd) begin found = 1'b1; break; end
      end
      chk("t5_cmd_seen", {31'b0, found}, 32'd1);
      @(negedge clk); #3;
      rst = 1'b0; ic_q.delete(); dc_q.delete(); ic_m = 16'h0; dc_m = 16'h0;
      #1;
      chk_zero_outputs("t5_async_reset");
      ic_req = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      late_ack_check("t5_post_reset_ack_nodone");
      mem_en = 1'b1; lat_fixed = 0;
      idle_gap();
      ic_txn(16'h0044, dcyc);
      chk("t5_cnt_after", {ic_gnt_cnt, dc_gnt_cnt}, {ic_m, dc_m});

      // Grant counter saturation from a preset near the top.
      @(negedge clk);
      force dut.ic_cnt = 16'hFFFC;
      @(negedge clk);
      release dut.ic_cnt;
      ic_m = 16'hFFFC;
      #1;
      for (int i = 0; i < 5; i++) begin
         idle_gap();
         ic_txn(16'h0040 + 16'(i), dcyc);
         chk("t6_sat_cnt", ic_gnt_cnt, ic_m);
      end

      // Randomised concurrent traffic with random busy and latency.
      rand_busy_en = 1'b1; lat_fixed = 0;
      fork
         begin
            int d1;
            repeat (40) begin
               repeat ($urandom_range(0, 3)) @(negedge clk);
               ic_txn(16'h0040 + 16'($urandom_range(0, 15)), d1);
            end
         end
         begin
            int d2;
            repeat (40) begin
               repeat ($urandom_range(0, 3)) @(negedge clk);
               dc_txn(1'($urandom_range(0, 1)), 16'h1000 + 16'($urandom_range(0, 15)),
                      16'($urandom), 1'b0, d2);
            end
         end
      join
      rand_busy_en = 1'b0;
      repeat (3) @(negedge clk); #1;
      chk("rand_queues_empty", ic_q.size() + dc_q.size(), 0);
      chk("rand_cnts", {ic_gnt_cnt, dc_gnt_cnt}, {ic_m, dc_m});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
